alarm_ctrl: RTL and testbench
=============================

# alarm_ctrl

Alarm-time controller for the digital clock. It holds the user-set alarm time and compares it against the running clock time. It produces the `alarmFlag` level that drives the LED blinker, and handles arming, snooze, dismiss and ring timeout. It sits between the timekeeping counters and switch/button debouncers on one side and the blinker on the other.

## Interface
- `RING_SECS`, 60: seconds the alarm rings before auto-timeout (≥2).
- `SNOOZE_SECS`, 300: seconds of silence after a snooze (≥2).
- `MAX_SNOOZE`, 3: snoozes allowed per alarm event (≥1).

- `CLK`  in  1  system clock; the only clock.
- `RST`  in  1  asynchronous, active-high reset.
- `tick_1hz`  in  1  one-`CLK` strobe, once per second.
- `cur_hour`  in  5  current hour, 0–23.
- `cur_min`  in  6  current minute, 0–59.
- `cur_sec`  in  6  current second, 0–59.
- `set_en`  in  1  one-cycle pulse; loads `set_hour`/`set_min` as the alarm time.
- `set_hour`  in  5  new alarm hour.
- `set_min`  in  6  new alarm minute.
- `arm_sw`  in  1  level; 1 = alarm enabled.
- `snooze`  in  1  one-cycle debounced pulse.
- `dismiss`  in  1  one-cycle debounced pulse.
- `alarmFlag`  out  1  registered; high while ringing.
- `armed`  out  1  registered; high when state ≠ IDLE.
- `snoozing`  out  1  registered; high in SNOOZE.
- `alm_hour`  out  5  stored alarm hour.
- `alm_min`  out  6  stored alarm minute.
- `snooze_left`  out  2  snoozes remaining for the current event.

## Operation
- States: IDLE, ARMED, RINGING, SNOOZE.
- Reset values: state IDLE, `alm_hour`=0, `alm_min`=0, all counters 0, `alarmFlag`=0, `armed`=0, `snoozing`=0, `snooze_left`=MAX_SNOOZE.
- Alarm-time load:
  - `set_en` with `set_hour`≤23 and `set_min`≤59 updates both registers on the next edge.
  - An out-of-range value rejects the whole load and keeps the old time.
  - A load in RINGING or SNOOZE moves the FSM to ARMED and restores `snooze_left`.
- Hit detection:
  - `hit` = (`cur_hour`==`alm_hour`) && (`cur_min`==`alm_min`) && (`cur_sec`==0).
  - `hit_d` is `hit` registered.
  - `trigger` = `hit` && !`hit_d`. It fires once per matching minute, and only from ARMED.
- IDLE → ARMED: when `arm_sw`=1.
- `arm_sw`=0 in any state: → IDLE next edge. `alarmFlag` drops, counters clear, `snooze_left` restores.
- ARMED → RINGING: on `trigger`. The ring counter clears.
- RINGING:
  - The ring counter increments on each `tick_1hz`.
  - A tick with counter = RING_SECS−1 → ARMED (timeout). `snooze_left` restores.
  - `dismiss` → ARMED. `snooze_left` restores.
  - `snooze` with `snooze_left`>0 → SNOOZE. `snooze_left` decrements and the snooze counter clears.
  - `snooze` with `snooze_left`=0 is ignored; the alarm keeps ringing.
- SNOOZE:
  - The snooze counter increments on each `tick_1hz`.
  - A tick with counter = SNOOZE_SECS−1 → RINGING. The ring counter clears.
  - `dismiss` → ARMED. `snooze_left` restores.
  - `snooze` is ignored.
- Simultaneous events, in priority order: `RST` > `arm_sw`=0 > `set_en` > `dismiss` > `snooze` > timer expiry > `trigger`. For example, `dismiss` and `snooze` in the same cycle act as `dismiss`.
- A `trigger` while in RINGING or SNOOZE has no effect.
- Counter width is sized to hold max(RING_SECS, SNOOZE_SECS)−1. Counters never wrap; they clear on every state entry.

## Timing
- All outputs are registered. `alarmFlag` = (next state == RINGING), updated on the edge that enters the state.
- Latency:
  - `trigger` at edge N: `alarmFlag`=1 after edge N.
  - `dismiss`, `snooze` or `arm_sw`=0 sampled at edge M: `alarmFlag`=0 after edge M.
- Ring length is exactly RING_SECS ticks counted from entry. A partial first second counts as a full second.
- `RST` assertion mid-ring clears `alarmFlag` immediately (asynchronous), with no clock edge needed. Release is synchronous to `CLK`.
- `set_en` takes effect on the next edge. A `hit` against the new time can trigger on the following cycle.

## Test plan
- Load with `arm_sw`=1: load 07:30, then drive time 07:29:59 → 07:30:00 on a tick → `alarmFlag` rises one cycle after the match. It stays high while `cur_sec` is 0, with no re-trigger.
- Ring timeout: RING_SECS=4, ringing with no input → `alarmFlag` falls on the 4th tick; state is ARMED and `snooze_left`=3.
- Snooze exhaustion: SNOOZE_SECS=3, MAX_SNOOZE=3.
  - Snooze three times → each time `alarmFlag`=0 for 3 ticks, then 1 again; `snooze_left` goes 2, 1, 0.
  - A 4th `snooze` → ignored, `alarmFlag` stays 1.
- Invalid load: load 24:10 → `alm_hour`/`alm_min` unchanged.
- Invalid load: load 12:60 → `alm_hour`/`alm_min` unchanged.
- `dismiss` and `snooze` in the same cycle → ARMED, `alarmFlag`=0, `snooze_left`=3.
- Abort cases:
  - `arm_sw`=0 during SNOOZE → IDLE, `armed`=0, `snoozing`=0; a later match does not ring.
  - `RST` pulse mid-ring → `alarmFlag`=0 with no clock edge; alarm time reads 00:00.

Source files
------------

// File: rtl/alarm_ctrl.sv
// Alarm-time controller: stores the alarm time, detects the minute match
// against the running clock, and sequences ring / snooze / dismiss / timeout.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | arm switch off; no alarm activity
// S_ARMED   | waiting for the clock to reach the alarm time
// S_RINGING | alarm sounding; ring counter counts seconds to timeout
// S_SNOOZE  | silenced after snooze; snooze counter counts down the pause
module alarm_ctrl #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       tick_1hz,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    input  logic       set_en,
    input  logic [4:0] set_hour,
    input  logic [5:0] set_min,
    input  logic       arm_sw,
    input  logic       snooze,
    input  logic       dismiss,
    output logic       alarmFlag,
    output logic       armed,
    output logic       snoozing,
    output logic [4:0] alm_hour,
    output logic [5:0] alm_min,
    output logic [1:0] snooze_left
);

    localparam int CNT_MAX = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
    localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] RING_LAST = CW'(RING_SECS - 1);
    localparam logic [CW-1:0] SNZ_LAST  = CW'(SNOOZE_SECS - 1);
    localparam logic [1:0]    SNZ_INIT  = 2'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_RINGING,
        S_SNOOZE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [1:0]      r_snz_left;
    logic [1:0]      w_snz_left_nxt;
    logic            r_hit_d;
    logic            r_alarm;
    logic            r_armed;
    logic            r_snoozing;
    logic [4:0]      r_alm_hour;
    logic [5:0]      r_alm_min;
    logic            w_hit;
    logic            w_trigger;
    logic            w_load_ok;

    assign w_load_ok = set_en && (set_hour <= 5'd23) && (set_min <= 6'd59);
    assign w_hit     = (cur_hour == r_alm_hour) && (cur_min == r_alm_min) && (cur_sec == 6'd0);
    assign w_trigger = w_hit && !r_hit_d;

    // Next-state, counter and snooze-budget logic; event priority is encoded
    // by the if/else order within each state.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_snz_left_nxt = r_snz_left;
        if (!arm_sw) begin
            w_state_nxt    = S_IDLE;
            w_snz_left_nxt = SNZ_INIT;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt    = S_ARMED;
                    w_snz_left_nxt = SNZ_INIT;
                end
                S_ARMED: begin
                    // a valid load outranks a trigger in the same cycle
                    if (!w_load_ok && w_trigger) begin
                        w_state_nxt = S_RINGING;
                    end
                end
                S_RINGING: begin
                    if (w_load_ok || dismiss) begin
                        w_state_nxt    = S_ARMED;
                        w_snz_left_nxt = SNZ_INIT;
                    end else if (snooze && (r_snz_left != 2'd0)) begin
                        w_state_nxt    = S_SNOOZE;
                        w_snz_left_nxt = r_snz_left - 2'd1;
                    end else if (tick_1hz) begin
                        if (r_cnt == RING_LAST) begin
                            w_state_nxt    = S_ARMED;
                            w_snz_left_nxt = SNZ_INIT;
                        end else begin
                            w_cnt_nxt = r_cnt + CW'(1);
                        end
                    end
                end
                S_SNOOZE: begin
                    if (w_load_ok || dismiss) begin
                        w_state_nxt    = S_ARMED;
                        w_snz_left_nxt = SNZ_INIT;
                    end else if (tick_1hz) begin
                        if (r_cnt == SNZ_LAST) begin
                            w_state_nxt = S_RINGING;
                        end else begin
                            w_cnt_nxt = r_cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
        // every state entry starts its timer from zero
        if (w_state_nxt != r_state) begin
            w_cnt_nxt = '0;
        end
    end

    // State, timer and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_snz_left <= SNZ_INIT;
            r_hit_d    <= 1'b0;
            r_alarm    <= 1'b0;
            r_armed    <= 1'b0;
            r_snoozing <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_snz_left <= w_snz_left_nxt;
            r_hit_d    <= w_hit;
            r_alarm    <= (w_state_nxt == S_RINGING);
            r_armed    <= (w_state_nxt != S_IDLE);
            r_snoozing <= (w_state_nxt == S_SNOOZE);
        end
    end

    // Alarm-time registers; an out-of-range hour or minute drops the whole load.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_alm_hour <= 5'd0;
            r_alm_min  <= 6'd0;
        end else if (w_load_ok) begin
            r_alm_hour <= set_hour;
            r_alm_min  <= set_min;
        end
    end

    assign alarmFlag   = r_alarm;
    assign armed       = r_armed;
    assign snoozing    = r_snoozing;
    assign alm_hour    = r_alm_hour;
    assign alm_min     = r_alm_min;
    assign snooze_left = r_snz_left;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl with short ring/snooze periods.
module tb_alarm_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       tick_1hz = 1'b0;
    logic [4:0] cur_hour = 5'd0;
    logic [5:0] cur_min = 6'd0;
    logic [5:0] cur_sec = 6'd1;
    logic       set_en = 1'b0;
    logic [4:0] set_hour = 5'd0;
    logic [5:0] set_min = 6'd0;
    logic       arm_sw = 1'b0;
    logic       snooze = 1'b0;
    logic       dismiss = 1'b0;
    logic       alarmFlag;
    logic       armed;
    logic       snoozing;
    logic [4:0] alm_hour;
    logic [5:0] alm_min;
    logic [1:0] snooze_left;

    int total = 0;
    int bad   = 0;

    alarm_ctrl #(
        .RING_SECS   (4),
        .SNOOZE_SECS (3),
        .MAX_SNOOZE  (3)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .tick_1hz    (tick_1hz),
        .cur_hour    (cur_hour),
        .cur_min     (cur_min),
        .cur_sec     (cur_sec),
        .set_en      (set_en),
        .set_hour    (set_hour),
        .set_min     (set_min),
        .arm_sw      (arm_sw),
        .snooze      (snooze),
        .dismiss     (dismiss),
        .alarmFlag   (alarmFlag),
        .armed       (armed),
        .snoozing    (snoozing),
        .alm_hour    (alm_hour),
        .alm_min     (alm_min),
        .snooze_left (snooze_left)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic one_tick();
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        step();
    endtask

    task automatic load(input logic [4:0] h, input logic [5:0] m);
        set_hour = h;
        set_min  = m;
        set_en   = 1'b1;
        step();
        set_en   = 1'b0;
    endtask

    // load h:m, approach it from second 59, then hit second 0
    task automatic ring_at(input logic [4:0] h, input logic [5:0] m);
        load(h, m);
        cur_hour = h;
        cur_min  = m;
        cur_sec  = 6'd59;
        step();
        cur_sec  = 6'd0;
        step();
    endtask

    initial begin
        #1 RST = 1'b1;
        #1;
        chk("rst_flag", 32'(alarmFlag), 0);
        chk("rst_armed", 32'(armed), 0);
        chk("rst_snoozing", 32'(snoozing), 0);
        chk("rst_hour", 32'(alm_hour), 0);
        chk("rst_min", 32'(alm_min), 0);
        chk("rst_left", 32'(snooze_left), 3);
        step();
        step();
        RST = 1'b0;
        step();

        arm_sw = 1'b1;
        step();
        chk("arm_armed", 32'(armed), 1);

        // first alarm at 07:30
        load(5'd7, 6'd30);
        chk("load_hour", 32'(alm_hour), 7);
        chk("load_min", 32'(alm_min), 30);
        cur_hour = 5'd7; cur_min = 6'd29; cur_sec = 6'd59;
        step();
        chk("pre_match_flag", 32'(alarmFlag), 0);
        cur_min = 6'd30; cur_sec = 6'd0; tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        chk("match_flag", 32'(alarmFlag), 1);
        step();
        step();
        chk("hold_flag", 32'(alarmFlag), 1);
        cur_sec = 6'd1;

        // ring timeout after 4 ticks
        one_tick();
        one_tick();
        one_tick();
        chk("ring_t3_flag", 32'(alarmFlag), 1);
        one_tick();
        chk("timeout_flag", 32'(alarmFlag), 0);
        chk("timeout_armed", 32'(armed), 1);
        chk("timeout_left", 32'(snooze_left), 3);

        // invalid loads keep 07:30
        load(5'd24, 6'd10);
        chk("bad_hour_h", 32'(alm_hour), 7);
        chk("bad_hour_m", 32'(alm_min), 30);
        load(5'd12, 6'd60);
        chk("bad_min_h", 32'(alm_hour), 7);
        chk("bad_min_m", 32'(alm_min), 30);

        // snooze exhaustion
        ring_at(5'd8, 6'd0);
        chk("snz_ring_flag", 32'(alarmFlag), 1);
        cur_sec = 6'd1;
        for (int k = 0; k < 3; k++) begin
            snooze = 1'b1;
            step();
            snooze = 1'b0;
            chk("snz_flag", 32'(alarmFlag), 0);
            chk("snz_snoozing", 32'(snoozing), 1);
            chk("snz_left", 32'(snooze_left), 32'(2 - k));
            one_tick();
            one_tick();
            chk("snz_t2_flag", 32'(alarmFlag), 0);
            one_tick();
            chk("snz_t3_flag", 32'(alarmFlag), 1);
            chk("snz_t3_snoozing", 32'(snoozing), 0);
        end
        snooze = 1'b1;
        step();
        snooze = 1'b0;
        chk("snz4_flag", 32'(alarmFlag), 1);
        chk("snz4_left", 32'(snooze_left), 0);
        chk("snz4_snoozing", 32'(snoozing), 0);
        dismiss = 1'b1;
        step();
        dismiss = 1'b0;
        chk("dis_flag", 32'(alarmFlag), 0);
        chk("dis_left", 32'(snooze_left), 3);

        // dismiss beats snooze
        ring_at(5'd9, 6'd15);
        chk("ds_ring_flag", 32'(alarmFlag), 1);
        cur_sec = 6'd1;
        dismiss = 1'b1; snooze = 1'b1;
        step();
        dismiss = 1'b0; snooze = 1'b0;
        chk("ds_flag", 32'(alarmFlag), 0);
        chk("ds_snoozing", 32'(snoozing), 0);
        chk("ds_armed", 32'(armed), 1);
        chk("ds_left", 32'(snooze_left), 3);

        // disarm during snooze
        ring_at(5'd10, 6'd0);
        cur_sec = 6'd1;
        snooze = 1'b1;
        step();
        snooze = 1'b0;
        chk("abort_snoozing_pre", 32'(snoozing), 1);
        arm_sw = 1'b0;
        step();
        chk("abort_armed", 32'(armed), 0);
        chk("abort_snoozing", 32'(snoozing), 0);
        chk("abort_flag", 32'(alarmFlag), 0);
        chk("abort_left", 32'(snooze_left), 3);
        cur_sec = 6'd59;
        step();
        cur_sec = 6'd0;
        step();
        step();
        chk("disarmed_match_flag", 32'(alarmFlag), 0);
        cur_sec = 6'd1;

        // asynchronous reset mid-ring
        arm_sw = 1'b1;
        step();
        ring_at(5'd11, 6'd0);
        chk("prerst_flag", 32'(alarmFlag), 1);
        #2 RST = 1'b1;
        #1;
        chk("async_rst_flag", 32'(alarmFlag), 0);
        chk("async_rst_hour", 32'(alm_hour), 0);
        chk("async_rst_min", 32'(alm_min), 0);
        chk("async_rst_armed", 32'(armed), 0);
        step();
        RST = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
